uart_fb_row_loader: RTL and testbench
=====================================

# uart_fb_row_loader

Parametrised host-to-framebuffer row loader. It accepts a framed byte stream from the UART receiver and unpacks packed pixels of BPP bits. Each pixel is written to the single-port framebuffer RAM at row*WIDTH+col. After each frame it returns a one-byte answer (ACK/NAK) through the UART transmitter. It sits between the UART byte-level controller and the framebuffer RAM write port, and replaces the fixed 640-pixel, 3-bit, answer-less row transfer.

## Interface
Parameters:
- WIDTH, 640, pixels per row; WIDTH*BPP must be a multiple of 8
- HEIGHT, 480, rows in framebuffer
- BPP, 4, bits per pixel; legal values 1, 2, 4, 8
- TIMEOUT_CYC, 1000000, inter-byte timeout in clk_sys cycles
- SYNC_BYTE, 8'hA5, frame start marker
- derived: PPB = 8/BPP pixels per byte; NBYTES = WIDTH*BPP/8; ADDR_W = $clog2(WIDTH*HEIGHT)

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low; clock clk_sys
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte
- tx_data  out  8  answer byte
- tx_valid  out  1  answer byte valid
- tx_ready  in  1  transmitter accepts the answer
- fb_we  out  1  framebuffer write strobe
- fb_addr  out  ADDR_W  framebuffer write address
- fb_data  out  BPP  pixel value
- busy  out  1  high in any state other than IDLE
- frame_ok  out  1  one-cycle pulse when an ACK is accepted by the transmitter
- err_cnt  out  8  saturating count of NAKs plus timeouts

## Operation
- Frame format: SYNC_BYTE, ROW_HI, ROW_LO, NBYTES payload bytes, CHK.
  - CHK is the XOR of ROW_HI, ROW_LO and all payload bytes.
- A byte is accepted on any cycle with rx_valid && rx_ready.
- States and transitions:
  - IDLE: rx_ready=1. SYNC_BYTE -> ROW_HI. Any other byte is discarded and the FSM stays in IDLE.
  - ROW_HI -> ROW_LO -> PAYLOAD. row = {ROW_HI,ROW_LO}. row_bad = (row >= HEIGHT).
  - PAYLOAD: rx_ready=1. The accepted byte is latched and the FSM moves to UNPACK.
  - UNPACK: rx_ready=0. Emits PPB consecutive writes, one per cycle, MSB-first. Pixel k of the byte is bits [7-k*BPP -: BPP].
    - Each write increments col.
    - After the last write: if NBYTES payload bytes have been consumed, go to CKSUM; otherwise go to PAYLOAD.
  - row_bad: payload bytes are still consumed, but fb_we is held at 0 for the whole frame.
  - CKSUM: latches CHK and goes to ANSWER.
    - Answer byte: 8'h18 if row_bad; else 8'h06 (ACK) if CHK matches the running XOR; else 8'h15 (NAK).
  - ANSWER: rx_ready=0, tx_valid=1, tx_data stable until tx_ready. On handshake: go to IDLE, pulse frame_ok if the answer was ACK, otherwise increment err_cnt.
- A checksum failure does not roll back writes already made. The host retransmits the row, which overwrites the bad data.
- Timeout:
  - The counter clears on every accepted byte and counts only in ROW_HI, ROW_LO, PAYLOAD and CKSUM.
  - At count == TIMEOUT_CYC-1 the FSM returns to IDLE, err_cnt increments, and no answer is sent.
- err_cnt saturates at 255. It clears only on reset.
- fb_addr = row*WIDTH + col. Compute it with an ADDR_W-wide accumulator (base + col); no run-time multiplier. col wraps to 0 at frame start.

## Timing
- Reset values:
  - rx_ready=0 while rst_n=0, then 1 on the first cycle after release.
  - tx_valid=0, tx_data=0, fb_we=0, fb_addr=0, fb_data=0, busy=0, frame_ok=0, err_cnt=0.
- Payload byte accepted at cycle T: pixel writes occur on cycles T+1 .. T+PPB. rx_ready is low during T+1 .. T+PPB and returns high at T+PPB+1.
- fb_addr, fb_data and fb_we are registered and valid in the same cycle.
- CHK accepted at cycle T: tx_valid rises at T+2 (CKSUM at T+1, ANSWER at T+2).
- frame_ok is asserted in the cycle after the tx handshake. busy falls in that same cycle.
- Reset asserted mid-frame: the next edge forces IDLE. No further writes occur, and the partially received row is left as written.
- If a timeout and a byte acceptance fall in the same cycle, the byte wins and the counter clears.

## Test plan
Use WIDTH=8, HEIGHT=4, BPP=4, TIMEOUT_CYC=64.
1. Good frame. A5 00 02 12 34 56 78 CHK=0x02^0x12^0x34^0x56^0x78 -> writes addr 16..23 = 1,2,3,4,5,6,7,8; answer 0x06; frame_ok pulses once.
2. Bad checksum. The same frame with CHK XOR 0xFF -> the 8 writes still occur; answer 0x15; err_cnt=1; no frame_ok.
3. Row out of range. Row 00 04 -> no fb_we during the frame; answer 0x18; err_cnt increments.
4. Timeout. Send A5 00 01 12, then idle for 64 cycles -> the FSM returns to IDLE with no tx_valid and err_cnt increments. A following good frame is ACKed.
5. Backpressure. Hold tx_ready=0 for 20 cycles in ANSWER -> tx_data stays stable and rx_ready=0. Garbage bytes in IDLE before A5 are ignored.
6. Parameter sweep. Run BPP=1 and BPP=8 -> PPB writes per byte with MSB-first order; err_cnt saturates at 255 after 300 NAKs.

Source files
------------

// File: rtl/uart_fb_row_loader.sv
// Framed UART-to-framebuffer row loader: unpacks BPP-bit pixels MSB-first into RAM writes
// and answers each frame with ACK / NAK / bad-row through the UART transmitter.
module uart_fb_row_loader #(
    parameter int unsigned WIDTH       = 640,
    parameter int unsigned HEIGHT      = 480,
    parameter int unsigned BPP         = 4,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    localparam int unsigned PPB        = 8 / BPP,
    localparam int unsigned NBYTES     = WIDTH * BPP / 8,
    localparam int unsigned ADDR_W     = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [BPP-1:0]    fb_data,
    output logic              busy,
    output logic              frame_ok,
    output logic [7:0]        err_cnt
);

    localparam int unsigned PIX_W = $clog2(PPB + 1);
    localparam int unsigned BC_W  = $clog2(NBYTES + 1);
    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [PIX_W-1:0] PPB_L    = PIX_W'(PPB);
    localparam logic [BC_W-1:0]  NBYTES_L = BC_W'(NBYTES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] ANS_ACK = 8'h06;
    localparam logic [7:0] ANS_NAK = 8'h15;
    localparam logic [7:0] ANS_ROW = 8'h18;

    typedef enum logic [2:0] {
        StIdle, StRowHi, StRowLo, StPayload, StUnpack, StCksum, StAnswer
    } state_t;

    state_t              state_q, state_d;
    logic                ready_en_q;
    logic [7:0]          row_hi_q;
    logic                row_bad_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          shreg_q;
    logic [PIX_W-1:0]    pix_cnt_q;
    logic [BC_W-1:0]     byte_cnt_q;
    logic [7:0]          xor_q;
    logic                chk_got_q;
    logic [7:0]          answer_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [7:0]          err_q;
    logic                frame_ok_q;
    logic                fb_we_q;
    logic [ADDR_W-1:0]   fb_addr_q;
    logic [BPP-1:0]      fb_data_q;

    logic                accept, tmo_en, tmo_hit, emit, do_write, ans_hs;
    logic [15:0]         row_w;
    logic [7:0]          pix_src;

    // Row base as a constant-coefficient shift-add; it is computed once per frame and the
    // per-pixel address then comes from the incrementing accumulator.
    function automatic logic [ADDR_W-1:0] row_base(input logic [ADDR_W-1:0] r);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (r[i]) acc = acc + (ADDR_W'(WIDTH) << i);
        end
        return acc;
    endfunction

    assign tmo_en   = state_q inside {StRowHi, StRowLo, StPayload, StCksum};
    assign rx_ready = ready_en_q && ((state_q inside {StIdle, StRowHi, StRowLo, StPayload}) ||
                                     (state_q == StCksum && !chk_got_q));
    assign accept   = rx_valid && rx_ready;
    assign tmo_hit  = tmo_en && !accept && (tmo_q == TMO_LAST);
    assign row_w    = {row_hi_q, rx_data};
    assign emit     = (state_q == StUnpack) && (pix_cnt_q != PPB_L);
    assign do_write = (accept && state_q == StPayload) || emit;
    assign pix_src  = (state_q == StPayload) ? rx_data : shreg_q;
    assign ans_hs   = (state_q == StAnswer) && tx_ready;

    assign tx_valid = (state_q == StAnswer);
    assign tx_data  = answer_q;
    assign busy     = (state_q != StIdle);
    assign frame_ok = frame_ok_q;
    assign err_cnt  = err_q;
    assign fb_we    = fb_we_q;
    assign fb_addr  = fb_addr_q;
    assign fb_data  = fb_data_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept && rx_data == SYNC_BYTE) state_d = StRowHi;
            StRowHi:   if (accept) state_d = StRowLo;
            StRowLo:   if (accept) state_d = StPayload;
            StPayload: if (accept) state_d = StUnpack;
            StUnpack: begin
                if (pix_cnt_q == PPB_L) begin
                    state_d = (byte_cnt_q == NBYTES_L) ? StCksum : StPayload;
                end
            end
            StCksum:   if (chk_got_q) state_d = StAnswer;
            StAnswer:  if (tx_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        if (tmo_hit) state_d = StIdle;
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ready_en_q <= 1'b0;
            row_hi_q   <= '0;
            row_bad_q  <= 1'b0;
            addr_q     <= '0;
            shreg_q    <= '0;
            pix_cnt_q  <= '0;
            byte_cnt_q <= '0;
            xor_q      <= '0;
            chk_got_q  <= 1'b0;
            answer_q   <= '0;
            tmo_q      <= '0;
            err_q      <= '0;
            frame_ok_q <= 1'b0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            fb_we_q    <= 1'b0;
            frame_ok_q <= 1'b0;
            tmo_q      <= (accept || !tmo_en) ? '0 : tmo_q + 1'b1;

            if (accept) begin
                case (state_q)
                    StIdle: begin
                        xor_q      <= '0;
                        byte_cnt_q <= '0;
                    end
                    StRowHi: begin
                        row_hi_q <= rx_data;
                        xor_q    <= xor_q ^ rx_data;
                    end
                    StRowLo: begin
                        row_bad_q <= (32'(row_w) >= HEIGHT);
                        addr_q    <= row_base(ADDR_W'(row_w));
                        xor_q     <= xor_q ^ rx_data;
                    end
                    StPayload: begin
                        xor_q      <= xor_q ^ rx_data;
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                    end
                    StCksum: begin
                        chk_got_q <= 1'b1;
                        answer_q  <= row_bad_q ? ANS_ROW :
                                     (rx_data == xor_q) ? ANS_ACK : ANS_NAK;
                    end
                    default: ;
                endcase
            end

            // First pixel comes straight from the accepted byte so writes start at T+1.
            if (do_write) begin
                fb_we_q   <= !row_bad_q;
                fb_addr_q <= addr_q;
                fb_data_q <= pix_src[7 -: BPP];
                shreg_q   <= pix_src << BPP;
                addr_q    <= addr_q + 1'b1;
                pix_cnt_q <= (state_q == StPayload) ? PIX_W'(1) : pix_cnt_q + 1'b1;
            end

            if (state_q == StCksum && chk_got_q) chk_got_q <= 1'b0;
            if (ans_hs) frame_ok_q <= (answer_q == ANS_ACK);
            if (((ans_hs && answer_q != ANS_ACK) || tmo_hit) && err_q != 8'hFF) begin
                err_q <= err_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_fb_row_loader.sv
// Directed bench for uart_fb_row_loader: BPP=4 main instance plus BPP=1 and BPP=8 instances.
module tb_uart_fb_row_loader;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic            rst_n;
    logic [2:0][7:0] rxd;
    logic [2:0]      rxv, txr;
    logic [2:0]      rdy, txv, we, bsy, fok;
    logic [2:0][7:0] txd, erc;
    logic [2:0][4:0] fa;
    logic [3:0]      fd4;
    logic [0:0]      fd1;
    logic [7:0]      fd8;

    int tests = 0;
    int fails = 0;
    int mon_sel = 0;
    int fok_cnt = 0;
    logic [4:0] wa[$];
    logic [7:0] wd[$];
    logic [7:0] pl[8];

    uart_fb_row_loader #(.WIDTH(8), .HEIGHT(4), .BPP(4), .TIMEOUT_CYC(64), .SYNC_BYTE(8'hA5)) u4 (
        .clk_sys(clk_sys), .rst_n(rst_n), .rx_data(rxd[0]), .rx_valid(rxv[0]), .rx_ready(rdy[0]),
        .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(txr[0]), .fb_we(we[0]), .fb_addr(fa[0]),
        .fb_data(fd4), .busy(bsy[0]), .frame_ok(fok[0]), .err_cnt(erc[0]));

    uart_fb_row_loader #(.WIDTH(8), .HEIGHT(4), .BPP(1), .TIMEOUT_CYC(64), .SYNC_BYTE(8'hA5)) u1 (
        .clk_sys(clk_sys), .rst_n(rst_n), .rx_data(rxd[1]), .rx_valid(rxv[1]), .rx_ready(rdy[1]),
        .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(txr[1]), .fb_we(we[1]), .fb_addr(fa[1]),
        .fb_data(fd1), .busy(bsy[1]), .frame_ok(fok[1]), .err_cnt(erc[1]));

    uart_fb_row_loader #(.WIDTH(8), .HEIGHT(4), .BPP(8), .TIMEOUT_CYC(64), .SYNC_BYTE(8'hA5)) u8 (
        .clk_sys(clk_sys), .rst_n(rst_n), .rx_data(rxd[2]), .rx_valid(rxv[2]), .rx_ready(rdy[2]),
        .tx_data(txd[2]), .tx_valid(txv[2]), .tx_ready(txr[2]), .fb_we(we[2]), .fb_addr(fa[2]),
        .fb_data(fd8), .busy(bsy[2]), .frame_ok(fok[2]), .err_cnt(erc[2]));

    function automatic logic [7:0] fdat(input int s);
        case (s)
            0:       return {4'h0, fd4};
            1:       return {7'h0, fd1};
            default: return fd8;
        endcase
    endfunction

    always @(negedge clk_sys) begin
        if (we[mon_sel] === 1'b1) begin
            wa.push_back(fa[mon_sel]);
            wd.push_back(fdat(mon_sel));
        end
        if (fok[mon_sel] === 1'b1) fok_cnt++;
    end

    task automatic clear_log(input int s);
        mon_sel = s;
        wa.delete();
        wd.delete();
        fok_cnt = 0;
    endtask

    task automatic send_byte(input int s, input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk_sys);
        rxd[s] = b;
        rxv[s] = 1'b1;
        while (!rdy[s] && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        if (!rdy[s]) begin
            tests++; fails++;
            $display("FAIL send_byte inst%0d: rx_ready=%b after %0d cycles, required 1", s, rdy[s], n);
        end
        @(posedge clk_sys);
        #1 rxv[s] = 1'b0;
    endtask

    task automatic send_frame(input int s, input logic [7:0] hi, input logic [7:0] lo,
                              input int n, input logic [7:0] chk);
        send_byte(s, 8'hA5);
        send_byte(s, hi);
        send_byte(s, lo);
        for (int i = 0; i < n; i++) send_byte(s, pl[i]);
        send_byte(s, chk);
    endtask

    task automatic get_answer(input int s, input int hold, output logic [7:0] ans);
        int n;
        logic bad;
        n = 0;
        bad = 1'b0;
        @(negedge clk_sys);
        while (!txv[s] && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        if (!txv[s]) begin
            tests++; fails++;
            $display("FAIL answer_wait inst%0d: tx_valid=%b after %0d cycles, required 1", s, txv[s], n);
            ans = 8'hxx;
            return;
        end
        ans = txd[s];
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk_sys);
                if (txd[s] !== ans || rdy[s] !== 1'b0 || txv[s] !== 1'b1) bad = 1'b1;
            end
            tests++;
            if (bad) begin
                fails++;
                $display("FAIL backpressure_hold: tx_data=%h rx_ready=%b tx_valid=%b, required %h 0 1",
                         txd[s], rdy[s], txv[s], ans);
            end
        end
        txr[s] = 1'b1;
        @(posedge clk_sys);
        #1 txr[s] = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rxv = '0; txr = '0; rxd = '0;
        repeat (3) @(posedge clk_sys);
        #1;
        tests++;
        if (rdy[0] !== 1'b0) begin
            fails++; $display("FAIL reset_rx_ready_low: got %b, required 0", rdy[0]);
        end
        @(negedge clk_sys);
        rst_n = 1'b1;
        @(posedge clk_sys);
        #1;
        tests++;
        if ({rdy[0], txv[0], txd[0], we[0], fa[0], fd4, bsy[0], fok[0], erc[0]} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL reset_values: rdy=%b txv=%b txd=%h we=%b fa=%0d fd=%h busy=%b ok=%b err=%0d, required 1 0 00 0 0 0 0 0 0",
                     rdy[0], txv[0], txd[0], we[0], fa[0], fd4, bsy[0], fok[0], erc[0]);
        end
    endtask

    task automatic test_good_frame;
        logic [7:0] ans;
        logic bad;
        clear_log(0);
        pl = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00};
        send_byte(0, 8'hA5); send_byte(0, 8'h00); send_byte(0, 8'h02); send_byte(0, 8'h12);
        tests++;
        if ({we[0], fa[0], fd4} !== {1'b1, 5'd16, 4'd1}) begin
            fails++; $display("FAIL first_write_timing: we=%b addr=%0d data=%h, required 1 16 1", we[0], fa[0], fd4);
        end
        send_byte(0, 8'h34); send_byte(0, 8'h56); send_byte(0, 8'h78); send_byte(0, 8'h0A);
        tests++;
        if (txv[0] !== 1'b0) begin
            fails++; $display("FAIL chk_latency_t1: tx_valid=%b, required 0", txv[0]);
        end
        @(posedge clk_sys);
        #1;
        tests++;
        if (txv[0] !== 1'b1) begin
            fails++; $display("FAIL chk_latency_t2: tx_valid=%b, required 1", txv[0]);
        end
        get_answer(0, 0, ans);
        tests++;
        if ({frame_ok_now(), bsy[0]} !== 2'b10) begin
            fails++; $display("FAIL ack_frame_ok_busy: frame_ok=%b busy=%b, required 1 0", fok[0], bsy[0]);
        end
        repeat (2) @(negedge clk_sys);
        tests++;
        if (ans !== 8'h06) begin
            fails++; $display("FAIL good_answer: got %h, required 06", ans);
        end
        tests++;
        if (fok_cnt !== 1 || erc[0] !== 8'd0) begin
            fails++; $display("FAIL good_frame_ok: pulses=%0d err=%0d, required 1 0", fok_cnt, erc[0]);
        end
        bad = (wa.size() != 8);
        for (int i = 0; i < 8 && !bad; i++) bad = (wa[i] !== 5'(16 + i)) || (wd[i] !== 8'(i + 1));
        tests++;
        if (bad) begin
            fails++; $display("FAIL good_writes: %0d writes, first addr=%0d data=%h, required 8 writes 16..23 = 1..8",
                              wa.size(), (wa.size() > 0) ? wa[0] : 5'd0, (wd.size() > 0) ? wd[0] : 8'd0);
        end
    endtask

    function automatic logic frame_ok_now();
        return fok[0];
    endfunction

    task automatic test_bad_checksum;
        logic [7:0] ans;
        logic bad;
        clear_log(0);
        pl = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(0, 8'h00, 8'h02, 4, 8'hF5);
        get_answer(0, 0, ans);
        repeat (2) @(negedge clk_sys);
        tests++;
        if (ans !== 8'h15 || erc[0] !== 8'd1 || fok_cnt !== 0) begin
            fails++; $display("FAIL bad_checksum: ans=%h err=%0d pulses=%0d, required 15 1 0", ans, erc[0], fok_cnt);
        end
        bad = (wa.size() != 8);
        for (int i = 0; i < 8 && !bad; i++) bad = (wa[i] !== 5'(16 + i)) || (wd[i] !== 8'(i + 1));
        tests++;
        if (bad) begin
            fails++; $display("FAIL bad_checksum_writes: %0d writes, required 8 writes 16..23 = 1..8", wa.size());
        end
    endtask

    task automatic test_row_range;
        logic [7:0] ans;
        clear_log(0);
        pl = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(0, 8'h00, 8'h04, 4, 8'h0C);
        get_answer(0, 0, ans);
        repeat (2) @(negedge clk_sys);
        tests++;
        if (ans !== 8'h18 || erc[0] !== 8'd2 || wa.size() != 0 || fok_cnt !== 0) begin
            fails++; $display("FAIL row_range: ans=%h err=%0d writes=%0d pulses=%0d, required 18 2 0 0",
                              ans, erc[0], wa.size(), fok_cnt);
        end
    endtask

    task automatic test_timeout;
        logic [7:0] ans;
        logic seen_tx, bad;
        int n;
        send_byte(0, 8'hA5); send_byte(0, 8'h00); send_byte(0, 8'h01); send_byte(0, 8'h12);
        n = 0;
        seen_tx = 1'b0;
        while (bsy[0] && n < 200) begin
            @(posedge clk_sys);
            #1;
            n++;
            if (txv[0]) seen_tx = 1'b1;
        end
        tests++;
        if (n != 66 || seen_tx || erc[0] !== 8'd3) begin
            fails++; $display("FAIL timeout: idle after %0d cycles tx_seen=%b err=%0d, required 66 0 3", n, seen_tx, erc[0]);
        end
        clear_log(0);
        send_frame(0, 8'h00, 8'h01, 4, 8'h09);
        get_answer(0, 0, ans);
        repeat (2) @(negedge clk_sys);
        bad = (wa.size() != 8);
        for (int i = 0; i < 8 && !bad; i++) bad = (wa[i] !== 5'(8 + i)) || (wd[i] !== 8'(i + 1));
        tests++;
        if (ans !== 8'h06 || fok_cnt !== 1 || bad) begin
            fails++; $display("FAIL after_timeout_frame: ans=%h pulses=%0d writes=%0d, required 06 1 8 at 8..15",
                              ans, fok_cnt, wa.size());
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] ans;
        logic [7:0] exp_d[8];
        logic bad;
        exp_d = '{8'h9, 8'hA, 8'hB, 8'hC, 8'hD, 8'hE, 8'hF, 8'h0};
        clear_log(0);
        send_byte(0, 8'h00); send_byte(0, 8'hFF); send_byte(0, 8'h13);
        pl = '{8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(0, 8'h00, 8'h03, 4, 8'h0B);
        get_answer(0, 20, ans);
        repeat (2) @(negedge clk_sys);
        bad = (wa.size() != 8);
        for (int i = 0; i < 8 && !bad; i++) bad = (wa[i] !== 5'(24 + i)) || (wd[i] !== exp_d[i]);
        tests++;
        if (ans !== 8'h06 || fok_cnt !== 1 || bad || erc[0] !== 8'd3) begin
            fails++; $display("FAIL backpressure_frame: ans=%h pulses=%0d writes=%0d err=%0d, required 06 1 8 3",
                              ans, fok_cnt, wa.size(), erc[0]);
        end
    endtask

    task automatic test_reset_mid_frame;
        send_byte(0, 8'hA5); send_byte(0, 8'h00); send_byte(0, 8'h00);
        clear_log(0);
        send_byte(0, 8'h12);
        @(negedge clk_sys);
        rst_n = 1'b0;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        rst_n = 1'b1;
        repeat (10) @(negedge clk_sys);
        tests++;
        if (wa.size() != 1 || wa[0] !== 5'd0 || wd[0] !== 8'd1 || bsy[0] !== 1'b0 || erc[0] !== 8'd0) begin
            fails++; $display("FAIL reset_mid_frame: writes=%0d busy=%b err=%0d, required 1 write (0,1) 0 0",
                              wa.size(), bsy[0], erc[0]);
        end
    endtask

    task automatic test_bpp1;
        logic [7:0] ans;
        logic [7:0] exp_d[8];
        logic bad;
        exp_d = '{8'd1, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0};
        clear_log(1);
        pl[0] = 8'hB4;
        send_frame(1, 8'h00, 8'h02, 1, 8'hB6);
        get_answer(1, 0, ans);
        repeat (2) @(negedge clk_sys);
        bad = (wa.size() != 8);
        for (int i = 0; i < 8 && !bad; i++) bad = (wa[i] !== 5'(16 + i)) || (wd[i] !== exp_d[i]);
        tests++;
        if (ans !== 8'h06 || fok_cnt !== 1 || bad) begin
            fails++; $display("FAIL bpp1_frame: ans=%h pulses=%0d writes=%0d, required 06 1 8 (10110100 at 16..23)",
                              ans, fok_cnt, wa.size());
        end
    endtask

    task automatic test_bpp8;
        logic [7:0] ans;
        logic bad;
        clear_log(2);
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_frame(2, 8'h00, 8'h01, 8, 8'h89);
        get_answer(2, 0, ans);
        repeat (2) @(negedge clk_sys);
        bad = (wa.size() != 8);
        for (int i = 0; i < 8 && !bad; i++) bad = (wa[i] !== 5'(8 + i)) || (wd[i] !== pl[i]);
        tests++;
        if (ans !== 8'h06 || fok_cnt !== 1 || bad) begin
            fails++; $display("FAIL bpp8_frame: ans=%h pulses=%0d writes=%0d, required 06 1 8 (11..88 at 8..15)",
                              ans, fok_cnt, wa.size());
        end
    endtask

    task automatic test_saturation;
        logic [7:0] ans;
        pl[0] = 8'h00;
        for (int i = 0; i < 300; i++) begin
            send_frame(1, 8'h00, 8'h00, 1, 8'hFF);
            get_answer(1, 0, ans);
            if (i == 253) begin
                tests++;
                if (erc[1] !== 8'd254) begin
                    fails++; $display("FAIL err_cnt_254: got %0d, required 254", erc[1]);
                end
            end
        end
        tests++;
        if (erc[1] !== 8'd255 || ans !== 8'h15) begin
            fails++; $display("FAIL err_cnt_saturate: err=%0d ans=%h, required 255 15", erc[1], ans);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_row_range();
        test_timeout();
        test_backpressure();
        test_reset_mid_frame();
        test_bpp1();
        test_bpp8();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
